// File: rtl/cussen_seq.sv
// Serial sort / de-duplicate / successive-difference engine built around a single
// shared compare/swap unit; results are streamed with the rank of each original input.
module cussen_seq #(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_ptr,
  output logic [3:0]       unique_count,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SORT  = 3'd2;
  localparam logic [2:0] S_DEDUP = 3'd3;
  localparam logic [2:0] S_DIFF  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]       state;
  logic [WIDTH-1:0] sbuf   [N];
  logic [WIDTH-1:0] orig   [N];
  logic [WIDTH-1:0] diff_q [N];
  logic [3:0]       ptr_q  [N];
  logic [WIDTH-1:0] diff_n [N];
  logic [3:0]       ptr_n  [N];

  logic [3:0] in_k;
  logic [3:0] sj;
  logic [3:0] sp;
  logic [3:0] dk;
  logic [3:0] dw;
  logic [3:0] ucnt;
  logic [3:0] out_k;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       done_q;

  logic [3:0]       sj1;
  logic [3:0]       dk_prev;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] upper;
  logic             keep;
  logic             found;

  assign sj1     = sj + 4'd1;
  assign dk_prev = (dk == '0) ? '0 : dk - 4'd1;
  assign lower   = sbuf[sj];
  assign upper   = sbuf[sj1];
  // In-place dedup is safe: the write slot never passes the read slot, so
  // sbuf[dk-1] still holds its sorted value when element dk is examined.
  assign keep    = (dk == '0) || (sbuf[dk] != sbuf[dk_prev]);

  always_comb begin
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      diff_n[i] = '0;
      ptr_n[i]  = '0;
    end
    if (ucnt != '0) diff_n[0] = sbuf[0];
    for (int unsigned i = 1; i < N; i++) begin
      if (4'(i) < ucnt) diff_n[i] = sbuf[i] - sbuf[i-1];
    end
    for (int unsigned i = 0; i < N; i++) begin
      found = 1'b0;
      for (int unsigned m = 0; m < N; m++) begin
        if (!found && (4'(m) < ucnt) && (sbuf[m] == orig[i])) begin
          ptr_n[i] = 4'(m);
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_k        <= '0;
      sj          <= '0;
      sp          <= '0;
      dk          <= '0;
      dw          <= '0;
      ucnt        <= '0;
      out_k       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        sbuf[i]   <= '0;
        orig[i]   <= '0;
        diff_q[i] <= '0;
        ptr_q[i]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            sbuf[0] <= in_data;
            orig[0] <= in_data;
            in_k    <= 4'd1;
            busy_q  <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready_q) begin
            sbuf[in_k] <= in_data;
            orig[in_k] <= in_data;
            in_k       <= in_k + 4'd1;
            if (in_k == 4'(N-1)) begin
              in_ready_q <= 1'b0;
              sj         <= '0;
              sp         <= '0;
              state      <= S_SORT;
            end
          end
        end
        S_SORT: begin
          if (lower > upper) begin
            sbuf[sj]  <= upper;
            sbuf[sj1] <= lower;
          end
          if (sj == 4'(N-2)) begin
            sj <= '0;
            if (sp == 4'(N-2)) begin
              dk    <= '0;
              dw    <= '0;
              state <= S_DEDUP;
            end else begin
              sp <= sp + 4'd1;
            end
          end else begin
            sj <= sj1;
          end
        end
        S_DEDUP: begin
          if (keep) begin
            sbuf[dw] <= sbuf[dk];
            dw       <= dw + 4'd1;
          end
          if (dk == 4'(N-1)) begin
            ucnt  <= dw + {3'b000, keep};
            state <= S_DIFF;
          end else begin
            dk <= dk + 4'd1;
          end
        end
        S_DIFF: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (4'(i) >= ucnt) sbuf[i] <= '0;
            diff_q[i] <= diff_n[i];
            ptr_q[i]  <= ptr_n[i];
          end
          out_k       <= '0;
          out_valid_q <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_k == 4'(N-1)) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              in_k        <= '0;
              state       <= S_IDLE;
            end else begin
              out_k <= out_k + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_valid_q ? diff_q[out_k] : '0;
  assign out_ptr      = out_valid_q ? ptr_q[out_k] : '0;
  assign unique_count = out_valid_q ? ucnt : '0;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cussen_seq.sv
// Directed bench for cussen_seq: hand-computed vectors, latency, backpressure,
// done pulse, back-to-back start and mid-sort reset.
module tb_cussen_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_ptr;
  logic [3:0] unique_count;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc;

  logic [7:0] vin [9];
  logic [7:0] ed  [9];
  logic [3:0] ep  [9];

  cussen_seq #(.WIDTH(8), .N(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ptr(out_ptr), .unique_count(unique_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Feed vin[start..8]; returns at the negedge after the last accepting edge.
  task automatic send(input int start);
    int t;
    for (int i = start; i < 9; i++) begin
      in_data  = vin[i];
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("in_ready_wait", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic receive(input logic [3:0] exp_uc, input int stall_beat, input bit chk_lat);
    int t;
    for (int k = 0; k < 9; k++) begin
      t = 0;
      while (!out_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("out_valid", out_valid, 1);
      if (k == 0 && chk_lat) check("latency", cyc - acc_cyc, 74);
      check("done_early", done, 0);
      check("out_data", out_data, ed[k]);
      check("out_ptr", out_ptr, ep[k]);
      check("unique_count", unique_count, exp_uc);
      if (k == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, ed[k]);
          check("stall_ptr", out_ptr, ep[k]);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Vector 1 with a 3-cycle stall on beat 4
    vin = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4};
    ed  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    ep  = '{4'd4, 4'd2, 4'd8, 4'd0, 4'd6, 4'd1, 4'd7, 4'd5, 4'd3};
    send(0);
    check("busy_loaded", busy, 1);
    check("in_ready_sort", in_ready, 0);
    receive(4'd9, 4, 1'b1);

    // Vector 2: first beat accepted in the done cycle
    vin = '{8'd5, 8'd3, 8'd5, 8'd1, 8'd3, 8'd1, 8'd9, 8'd9, 8'd2};
    ed  = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    ep  = '{4'd3, 4'd2, 4'd3, 4'd0, 4'd2, 4'd0, 4'd4, 4'd4, 4'd1};
    in_data = vin[0]; in_valid = 1'b1;
    @(negedge clk);
    check("done_cycle_accept_busy", busy, 1);
    check("done_one_cycle", done, 0);
    send(1);
    receive(4'd5, -1, 1'b1);

    // Vector 3: all equal
    for (int i = 0; i < 9; i++) begin
      vin[i] = 8'd200; ed[i] = 8'd0; ep[i] = 4'd0;
    end
    ed[0] = 8'd200;
    send(0);
    receive(4'd1, -1, 1'b1);

    // Vector 4: zeros and one 255
    vin = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ed  = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ep  = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    send(0);
    receive(4'd2, -1, 1'b1);

    // Mid-sort reset, then vector 1 again
    vin = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4};
    ed  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    ep  = '{4'd4, 4'd2, 4'd8, 4'd0, 4'd6, 4'd1, 4'd7, 4'd5, 4'd3};
    send(0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_ptr", out_ptr, 0);
    check("mid_rst_uc", unique_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    send(0);
    receive(4'd9, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
